chord_song_reader: RTL and testbench
====================================

Name: chord_song_reader

Overview:
Sequencer that drives the three-voice chord_player. It walks a 512-entry song ROM and groups consecutive entries into chords. For each chord it issues note/duration/new_note per voice, then computes time_advance: the shortest remaining duration among sounding voices, so it never exceeds any note's duration. It counts beat ticks for that many beats before fetching the next chord, and flags song_done when the address overflows past 511.

Parameters:
ADDR_W, 9, ROM address width (512 entries; overflow bit ADDR_W marks end of song)
NOTE_W, 6, note code width
DUR_W, 6, duration width in beats
WORD_W, 15, ROM word width = 1 + 2 + NOTE_W + DUR_W

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins playback from address 0
beat  input  1  one-cycle beat tick enable
rom_addr  output  ADDR_W  synchronous ROM address (registered)
rom_data  input  WORD_W  ROM word, valid 1 cycle after rom_addr; fields {last_in_chord, voice[1:0], note, duration}
note1, note2, note3  output  NOTE_W  note code per voice (held)
duration1, duration2, duration3  output  DUR_W  duration per voice (held)
new_note1, new_note2, new_note3  output  1  one-cycle pulse when the voice gets a new note
time_advance  output  DUR_W  beats until the next chord fetch (held)
time_advance_ready  output  1  one-cycle pulse when time_advance is updated
song_done  output  1  level; high once the song has ended
busy  output  1  high in any state other than IDLE/DONE

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; internal 10-bit addr = 0; remaining counters rem1..3 = 0.
- States: IDLE, FETCH, READ, CALC, ADVANCE, DONE.
- IDLE: start -> FETCH with addr = 0, rem1..3 = 0, song_done cleared. start in any other state is ignored, except DONE, which behaves as in IDLE.
- FETCH: rom_addr = addr[ADDR_W-1:0]. Next cycle -> READ.
- READ: sample rom_data, then addr <= addr + 1.
  - voice 1..3 with duration != 0: set noteN and durationN, set remN = duration, pulse new_noteN this cycle.
  - voice 0 (rest) or duration 0: no output change and no pulse.
  - A later entry for the same voice within the chord overwrites the earlier one and pulses again.
  - If last_in_chord = 1, or the read was at address 511 (addr incremented to 512): -> CALC. Otherwise -> FETCH.
- CALC (1 cycle): time_advance = min(remN over remN != 0).
  - If any remN != 0: pulse time_advance_ready -> ADVANCE.
  - If all remN = 0: time_advance = 0, pulse time_advance_ready, then -> DONE if addr[ADDR_W] = 1, else -> FETCH.
- ADVANCE: internal beat counter bc starts at 0.
  - Each beat: bc++ and every nonzero remN decrements by 1.
  - When bc reaches time_advance (on that beat): -> DONE if addr[ADDR_W] = 1, else -> FETCH.
  - Voices whose remN reaches 0 are simply silent; their outputs are held, not cleared.
- Beats outside ADVANCE are ignored.
- DONE: song_done = 1 (held), busy = 0.
- Per-entry cost is 2 cycles; chord-to-first-new_note latency after the ADVANCE exit is 2 cycles.
- All outputs are registered. Pulses last exactly one cycle.
- Reset mid-playback returns to IDLE immediately; no pulses are emitted afterwards.

Decomposition:
- Shared package: NOTE_W, DUR_W, ADDR_W, WORD_W; field-offset constants LAST_BIT, VOICE_MSB/LSB, NOTE_MSB/LSB, DUR_MSB/LSB; state enum.
- One sub-module: min3_nonzero. Combinational min over three DUR_W values ignoring zeros; returns 0 and all_zero = 1 when all inputs are 0.

Test Plan:
- ROM[0] = {0,v1,n=10,d=4}, ROM[1] = {0,v2,n=14,d=2}, ROM[2] = {1,v3,n=17,d=6}; start -> new_note1/2/3 pulse in order; time_advance = 2 with ready pulse; after 2 beats rom_addr = 3; rem1 = 2, rem3 = 4.
- Chord with only voice 0 and d=0 entries marked last -> time_advance = 0, ready pulse, immediate FETCH with no beat waits.
- Two entries for voice 1 in one chord (d=5 then d=3) -> two new_note1 pulses; duration1 = 3; time_advance = 3.
- Fill ROM so that address 511 holds last_in_chord = 0 -> chord closes at 511; after its advance completes song_done = 1, busy = 0; further beats and new start produce no output until start restarts from 0.
- Assert reset during ADVANCE with 1 beat remaining -> all outputs 0 immediately; no new_note or ready pulses until the next start.
- Pulse start while busy, and pulse beat during FETCH/READ -> both ignored; beat count for time_advance = 4 is still exactly 4 ADVANCE beats.

Source files
------------

// File: rtl/chord_song_reader_pkg.sv
// Shared widths, ROM word field offsets and sequencer states for the chord song reader.
package chord_song_reader_pkg;

    localparam int ADDR_W = 9;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int WORD_W = 1 + 2 + NOTE_W + DUR_W;

    // ROM word layout: {last_in_chord, voice[1:0], note, duration}
    localparam int DUR_LSB   = 0;
    localparam int DUR_MSB   = DUR_LSB + DUR_W - 1;
    localparam int NOTE_LSB  = DUR_MSB + 1;
    localparam int NOTE_MSB  = NOTE_LSB + NOTE_W - 1;
    localparam int VOICE_LSB = NOTE_MSB + 1;
    localparam int VOICE_MSB = VOICE_LSB + 1;
    localparam int LAST_BIT  = VOICE_MSB + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_CALC,
        S_ADVANCE,
        S_DONE
    } state_t;

endpackage

// File: rtl/chord_song_reader_min3.sv
// Minimum of three durations ignoring zeros; all_zero flags that none is sounding.
module min3_nonzero
    import chord_song_reader_pkg::*;
(
    input  logic [DUR_W-1:0] a,
    input  logic [DUR_W-1:0] b,
    input  logic [DUR_W-1:0] c,
    output logic [DUR_W-1:0] min_val,
    output logic             all_zero
);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        min_val = '0;
        if (a != '0) min_val = a;
        if (b != '0 && (min_val == '0 || b < min_val)) min_val = b;
        if (c != '0 && (min_val == '0 || c < min_val)) min_val = c;
        all_zero = (min_val == '0);
    end

endmodule

// File: rtl/chord_song_reader.sv
// Walks the song ROM, groups entries into chords for the three-voice player,
// and waits time_advance beats (shortest remaining note) between chords.
module chord_song_reader
    import chord_song_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              beat,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [NOTE_W-1:0] note1,
    output logic [NOTE_W-1:0] note2,
    output logic [NOTE_W-1:0] note3,
    output logic [DUR_W-1:0]  duration1,
    output logic [DUR_W-1:0]  duration2,
    output logic [DUR_W-1:0]  duration3,
    output logic              new_note1,
    output logic              new_note2,
    output logic              new_note3,
    output logic [DUR_W-1:0]  time_advance,
    output logic              time_advance_ready,
    output logic              song_done,
    output logic              busy
);

    state_t            state;
    logic [ADDR_W:0]   addr;
    logic [ADDR_W:0]   addr_inc;
    logic [DUR_W-1:0]  rem1, rem2, rem3;
    logic [DUR_W-1:0]  bc;
    logic [DUR_W-1:0]  bc_next;
    logic [DUR_W-1:0]  min_rem;
    logic              rem_all_zero;

    logic              entry_last;
    logic [1:0]        entry_voice;
    logic [NOTE_W-1:0] entry_note;
    logic [DUR_W-1:0]  entry_dur;

    assign entry_last  = rom_data[LAST_BIT];
    assign entry_voice = rom_data[VOICE_MSB:VOICE_LSB];
    assign entry_note  = rom_data[NOTE_MSB:NOTE_LSB];
    assign entry_dur   = rom_data[DUR_MSB:DUR_LSB];

    assign addr_inc = addr + 1'b1;
    assign bc_next  = bc + 1'b1;

    min3_nonzero u_min3 (
        .a        (rem1),
        .b        (rem2),
        .c        (rem3),
        .min_val  (min_rem),
        .all_zero (rem_all_zero)
    );

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            addr               <= '0;
            rem1               <= '0;
            rem2               <= '0;
            rem3               <= '0;
            bc                 <= '0;
            rom_addr           <= '0;
            note1              <= '0;
            note2              <= '0;
            note3              <= '0;
            duration1          <= '0;
            duration2          <= '0;
            duration3          <= '0;
            new_note1          <= 1'b0;
            new_note2          <= 1'b0;
            new_note3          <= 1'b0;
            time_advance       <= '0;
            time_advance_ready <= 1'b0;
            song_done          <= 1'b0;
            busy               <= 1'b0;
        end else begin
            new_note1          <= 1'b0;
            new_note2          <= 1'b0;
            new_note3          <= 1'b0;
            time_advance_ready <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        addr      <= '0;
                        rom_addr  <= '0;
                        rem1      <= '0;
                        rem2      <= '0;
                        rem3      <= '0;
                        song_done <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                // rom_addr was loaded on entry; the ROM registers it this cycle.
                S_FETCH: state <= S_READ;

                S_READ: begin
                    addr <= addr_inc;
                    if (entry_dur != '0) begin
                        case (entry_voice)
                            2'd1: begin
                                note1 <= entry_note; duration1 <= entry_dur;
                                rem1  <= entry_dur;  new_note1 <= 1'b1;
                            end
                            2'd2: begin
                                note2 <= entry_note; duration2 <= entry_dur;
                                rem2  <= entry_dur;  new_note2 <= 1'b1;
                            end
                            2'd3: begin
                                note3 <= entry_note; duration3 <= entry_dur;
                                rem3  <= entry_dur;  new_note3 <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (entry_last || addr_inc[ADDR_W]) begin
                        state <= S_CALC;
                    end else begin
                        state    <= S_FETCH;
                        rom_addr <= addr_inc[ADDR_W-1:0];
                    end
                end

                S_CALC: begin
                    time_advance       <= min_rem;
                    time_advance_ready <= 1'b1;
                    if (!rem_all_zero) begin
                        state <= S_ADVANCE;
                        bc    <= '0;
                    end else if (addr[ADDR_W]) begin
                        state     <= S_DONE;
                        song_done <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state    <= S_FETCH;
                        rom_addr <= addr[ADDR_W-1:0];
                    end
                end

                S_ADVANCE: begin
                    if (beat) begin
                        bc   <= bc_next;
                        rem1 <= (rem1 != '0) ? rem1 - 1'b1 : rem1;
                        rem2 <= (rem2 != '0) ? rem2 - 1'b1 : rem2;
                        rem3 <= (rem3 != '0) ? rem3 - 1'b1 : rem3;
                        if (bc_next == time_advance) begin
                            if (addr[ADDR_W]) begin
                                state     <= S_DONE;
                                song_done <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                state    <= S_FETCH;
                                rom_addr <= addr[ADDR_W-1:0];
                            end
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chord_song_reader.sv
// Self-checking bench: a procedural song-playing model predicts every output
// each cycle; a few hand-computed chord results pin the model itself.
module tb_chord_song_reader;

    localparam int ADDR_W = 9;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int WORD_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              beat;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data = '0;
    logic [NOTE_W-1:0] note1, note2, note3;
    logic [DUR_W-1:0]  duration1, duration2, duration3;
    logic              new_note1, new_note2, new_note3;
    logic [DUR_W-1:0]  time_advance;
    logic              time_advance_ready;
    logic              song_done;
    logic              busy;

    chord_song_reader dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .beat               (beat),
        .rom_addr           (rom_addr),
        .rom_data           (rom_data),
        .note1              (note1),
        .note2              (note2),
        .note3              (note3),
        .duration1          (duration1),
        .duration2          (duration2),
        .duration3          (duration3),
        .new_note1          (new_note1),
        .new_note2          (new_note2),
        .new_note3          (new_note3),
        .time_advance       (time_advance),
        .time_advance_ready (time_advance_ready),
        .song_done          (song_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] rom [512];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk(input logic last, input logic [1:0] voice,
                                             input logic [5:0] note, input logic [5:0] dur);
        return {last, voice, note, dur};
    endfunction

    // ---------------- behavioural model ----------------
    logic [NOTE_W-1:0] exp_note [1:3];
    logic [DUR_W-1:0]  exp_dur  [1:3];
    logic [2:0]        exp_new;
    logic [DUR_W-1:0]  exp_ta;
    logic              exp_ready;
    logic              exp_done;
    logic              exp_busy;
    logic [ADDR_W-1:0] exp_rom_addr;
    logic [DUR_W-1:0]  m_rem [1:3];
    logic              m_abort;
    int                model_ta_log[$];
    logic [17:0]       model_rem_log[$];

    task automatic m_clear();
        for (int v = 1; v <= 3; v++) begin
            exp_note[v] = '0; exp_dur[v] = '0; m_rem[v] = '0;
        end
        exp_new = '0; exp_ta = '0; exp_ready = 1'b0;
        exp_done = 1'b0; exp_busy = 1'b0; exp_rom_addr = '0;
    endtask

    // One clock edge of the song; reset aborts whatever is being played.
    task automatic tick();
        @(posedge clk or posedge reset);
        if (reset) begin
            m_clear();
            m_abort = 1'b1;
        end else begin
            exp_new   = '0;
            exp_ready = 1'b0;
        end
    endtask

    task automatic play_song();
        int a;
        logic closed;
        logic [WORD_W-1:0] w;
        logic [DUR_W-1:0] ta;
        int beats;
        a = 0;
        for (int v = 1; v <= 3; v++) m_rem[v] = '0;
        exp_done = 1'b0; exp_busy = 1'b1; exp_rom_addr = '0;
        forever begin
            closed = 1'b0;
            while (!closed) begin
                tick(); if (m_abort) return;        // address presented to ROM
                tick(); if (m_abort) return;        // entry consumed
                w = rom[a];
                a++;
                if (w[13:12] != 2'd0 && w[5:0] != 6'd0) begin
                    exp_note[w[13:12]] = w[11:6];
                    exp_dur[w[13:12]]  = w[5:0];
                    m_rem[w[13:12]]    = w[5:0];
                    exp_new[w[13:12] - 2'd1] = 1'b1;
                end
                closed = w[14] || (a == 512);
                if (!closed) exp_rom_addr = a[ADDR_W-1:0];
            end
            tick(); if (m_abort) return;            // chord timing decided
            ta = '0;
            for (int v = 1; v <= 3; v++)
                if (m_rem[v] != 0 && (ta == 0 || m_rem[v] < ta)) ta = m_rem[v];
            exp_ta = ta; exp_ready = 1'b1;
            model_ta_log.push_back(int'(ta));
            model_rem_log.push_back({m_rem[1], m_rem[2], m_rem[3]});
            beats = 0;
            while (beats < int'(ta)) begin
                tick(); if (m_abort) return;
                if (beat) begin
                    beats++;
                    for (int v = 1; v <= 3; v++) if (m_rem[v] != 0) m_rem[v] = m_rem[v] - 1'b1;
                end
            end
            if (a == 512) begin
                exp_busy = 1'b0; exp_done = 1'b1;
                return;
            end
            exp_rom_addr = a[ADDR_W-1:0];
        end
    endtask

    initial begin
        m_clear();
        forever begin
            m_abort = 1'b0;
            tick();
            if (!m_abort && start) play_song();
        end
    end

    // ---------------- per-cycle compare ----------------
    int nn1_cnt   = 0;
    int pulse_cnt = 0;
    int dut_ta_log[$];
    int dut_note1_log[$];
    int dut_dur1_log[$];
    int dut_addr_log[$];
    int dut_nn1_log[$];

    initial forever begin
        @(negedge clk);
        check("notes_durs", {note1, note2, note3, duration1, duration2, duration3},
              {exp_note[1], exp_note[2], exp_note[3], exp_dur[1], exp_dur[2], exp_dur[3]});
        check("pulses", {new_note3, new_note2, new_note1, time_advance_ready}, {exp_new, exp_ready});
        check("time_advance", time_advance, exp_ta);
        check("status", {song_done, busy, rom_addr}, {exp_done, exp_busy, exp_rom_addr});
        if (new_note1) nn1_cnt++;
        pulse_cnt += int'(new_note1) + int'(new_note2) + int'(new_note3) + int'(time_advance_ready);
        if (time_advance_ready) begin
            dut_ta_log.push_back(int'(time_advance));
            dut_note1_log.push_back(int'(note1));
            dut_dur1_log.push_back(int'(duration1));
            dut_addr_log.push_back(int'(rom_addr));
            dut_nn1_log.push_back(nn1_cnt);
            nn1_cnt = 0;
        end
    end

    // ---------------- stimulus ----------------
    logic beat_rand  = 1'b0;
    logic start_rand = 1'b0;

    task automatic step();
        @(negedge clk);
        if (beat_rand)  beat  = 1'($urandom_range(0, 1));
        if (start_rand) start = exp_busy && ($urandom_range(0, 15) == 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {rom_addr, note1, note2, note3, duration1, duration2, duration3,
                     new_note1, new_note2, new_note3, time_advance, time_advance_ready,
                     song_done, busy}, 64'd0);
    endtask

    int exp_ta_lit [6] = '{2, 2, 2, 0, 3, 4};
    int snap;

    initial begin
        rom[0]  = mk(1'b0, 2'd1, 6'd10, 6'd4);
        rom[1]  = mk(1'b0, 2'd2, 6'd14, 6'd2);
        rom[2]  = mk(1'b1, 2'd3, 6'd17, 6'd6);
        rom[3]  = mk(1'b1, 2'd0, 6'd5,  6'd0);   // rest-only chord, rem1/rem3 still sound
        rom[4]  = mk(1'b1, 2'd1, 6'd0,  6'd0);   // zero-duration entry, drains to silence
        rom[5]  = mk(1'b0, 2'd0, 6'd8,  6'd3);
        rom[6]  = mk(1'b1, 2'd2, 6'd9,  6'd0);   // all silent -> time_advance 0
        rom[7]  = mk(1'b0, 2'd1, 6'd20, 6'd5);
        rom[8]  = mk(1'b1, 2'd1, 6'd21, 6'd3);   // voice 1 overwritten in one chord
        rom[9]  = mk(1'b1, 2'd2, 6'd30, 6'd4);
        for (int i = 10; i < 511; i++)
            rom[i] = mk(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                        6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)));
        rom[511] = mk(1'b0, 2'd1, 6'd40, 6'd3);

        reset = 1'b1; start = 1'b0; beat = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        beat_rand = 1'b1; start_rand = 1'b1;

        for (int i = 0; i < 20000 && !song_done; i++) step();
        beat_rand = 1'b0; start_rand = 1'b0; beat = 1'b0; start = 1'b0;
        check("song_done_reached", {song_done, busy}, 64'b10);

        if (dut_ta_log.size() >= 6 && model_ta_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check("dut_chord_ta", dut_ta_log[i], exp_ta_lit[i]);
                check("model_chord_ta", model_ta_log[i], exp_ta_lit[i]);
            end
            check("model_rem_after_first_advance", model_rem_log[1], {6'd2, 6'd0, 6'd4});
            check("rom_addr_after_first_advance", dut_addr_log[1], 3);
            check("first_chord_note1", dut_note1_log[0], 10);
            check("overwrite_note1", dut_note1_log[4], 21);
            check("overwrite_duration1", dut_dur1_log[4], 3);
            check("overwrite_new_note1_pulses", dut_nn1_log[4], 2);
        end else begin
            check("ready_pulse_count", dut_ta_log.size(), 6);
        end

        // Beats after the end of the song change nothing.
        beat = 1'b1;
        repeat (6) step();
        beat = 1'b0;
        check("done_hold", {song_done, busy}, 64'b10);

        // Restart from address 0, then reset with one beat still to go.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !time_advance_ready; i++) step();
        check("restart_ta", {time_advance_ready, time_advance}, {1'b1, 6'd2});
        beat = 1'b1;
        step();
        beat = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("reset_mid_advance");
        repeat (2) step();
        reset = 1'b0;
        snap = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            beat = 1'(i % 2);
            step();
        end
        beat = 1'b0;
        check("no_pulses_after_reset", pulse_cnt - snap, 0);
        check("idle_after_reset", {song_done, busy, rom_addr}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
